data_mem_serial: RTL and testbench

//  Y86-64 data-memory stage that consumes memRead/memWrite from the memory-control decoder.

---
 rtl/y86_pkg.sv | 19 +
 rtl/data_mem_serial_if.sv | 23 ++
 rtl/dmem_byte_ram.sv | 23 ++
 rtl/data_mem_serial.sv | 119 +++++++++++
 tb/tb_data_mem_serial.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the serial data-memory stage.
package y86_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam int WORD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } dmem_state_t;

endpackage

// File: rtl/data_mem_serial_if.sv
// Request/response bundle between the memory-control decoder and the data-memory stage.
interface data_mem_serial_if;

    logic        memRead;
    logic        memWrite;
    logic [63:0] addr;
    logic [63:0] valIn;
    logic [63:0] valM;
    logic        memBusy;
    logic        memDone;
    logic        memError;

    modport master (
        output memRead, memWrite, addr, valIn,
        input  valM, memBusy, memDone, memError
    );

    modport slave (
        input  memRead, memWrite, addr, valIn,
        output valM, memBusy, memDone, memError
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// Byte-wide data RAM: synchronous write, asynchronous read, contents never reset.
module dmem_byte_ram #(
    parameter int MEM_BYTES = 4096,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_serial.sv
// Y86-64 data-memory stage: 8-byte little-endian accesses, one byte per cycle.
// Define DMEM_ALIGN_CHECK_EN to reject addresses that are not 8-byte aligned.
module data_mem_serial
    import y86_pkg::*;
#(
    parameter int MEM_BYTES  = 4096,
    parameter int WORD_BYTES = y86_pkg::WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_serial_if.slave  bus
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST_START = 64'(MEM_BYTES - WORD_BYTES);

    dmem_state_t   state_reg, state_next;
    logic [2:0]    cnt_reg;
    logic [AW-1:0] addr_reg;
    logic [63:0]   data_reg;
    logic          write_reg;
    logic [63:0]   shreg_reg;
    logic [63:0]   valm_reg;
    logic          err_reg;

    logic          req_any;
    logic          conflict;
    logic          out_of_range;
    logic          misaligned;
    logic          reject;
    logic          accept;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    assign req_any      = bus.memRead | bus.memWrite;
    assign conflict     = bus.memRead & bus.memWrite;
    assign out_of_range = (bus.addr > LAST_START);
`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned   = (bus.addr[2:0] != 3'd0);
`else
    assign misaligned   = 1'b0;
`endif
    assign reject = req_any & (conflict | out_of_range | misaligned);
    assign accept = req_any & ~reject;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = XFER;
            XFER:    if (cnt_reg == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The range check already passed, so this narrow sum cannot wrap.
    assign ram_addr  = addr_reg + AW'(cnt_reg);
    assign ram_we    = (state_reg == XFER) & write_reg;
    assign ram_wdata = data_reg[{cnt_reg, 3'b000} +: 8];

    dmem_byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            addr_reg  <= '0;
            data_reg  <= 64'd0;
            write_reg <= 1'b0;
            shreg_reg <= 64'd0;
            valm_reg  <= 64'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= (state_reg == IDLE) & reject;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= bus.addr[AW-1:0];
                        data_reg  <= bus.valIn;
                        write_reg <= bus.memWrite;
                        cnt_reg   <= 3'd0;
                    end
                end
                XFER: begin
                    if (!write_reg) begin
                        shreg_reg[{cnt_reg, 3'b000} +: 8] <= ram_rdata;
                    end
                    cnt_reg <= cnt_reg + 3'd1;
                end
                DONE: begin
                    if (!write_reg) begin
                        valm_reg <= shreg_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // During DONE of a read the assembled word is forwarded so valM is valid with memDone.
    assign bus.valM     = ((state_reg == DONE) && !write_reg) ? shreg_reg : valm_reg;
    assign bus.memBusy  = (state_reg != IDLE);
    assign bus.memDone  = (state_reg == DONE);
    assign bus.memError = err_reg;

endmodule

// File: tb/tb_data_mem_serial.sv
// Self-checking bench for data_mem_serial: transaction-level model plus literal spot checks.
module tb_data_mem_serial;

    localparam int MEM_BYTES = 4096;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [63:0] valm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_serial_if bus ();

    data_mem_serial #(
        .MEM_BYTES (MEM_BYTES)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t        exp_q[$];
    exp_t        cur_exp;
    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          busy_seen = 0;
    int          sample_no = 0;
    logic [7:0]  mem_model [MEM_BYTES];
    logic [63:0] model_valm = 64'd0;

    // Compare process: every sample point with a pending expectation is checked.
    always @(negedge clk) begin
        sample_no++;
        if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
            n_cmp++;
            if ({bus.memBusy, bus.memDone, bus.memError, bus.valM} !== cur_exp) begin
                n_bad++;
                $display("FAIL outputs@%0d: got busy=%b done=%b err=%b valM=%h, expected busy=%b done=%b err=%b valM=%h",
                         sample_no, bus.memBusy, bus.memDone, bus.memError, bus.valM,
                         cur_exp.busy, cur_exp.done, cur_exp.err, cur_exp.valm);
            end
        end
        if (bus.memBusy === 1'b1) busy_seen++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic cyc(input logic b, input logic d, input logic e, input logic [63:0] v);
        exp_q.push_back(exp_t'{busy: b, done: d, err: e, valm: v});
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.addr     = 64'd0;
        bus.valIn    = 64'd0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                          input logic [63:0] d, input string tag);
        logic        rej;
        logic [63:0] word;
        int          base;
        bus.memRead  = rd;
        bus.memWrite = wr;
        bus.addr     = a;
        bus.valIn    = d;
        rej = (rd && wr) || (a > 64'(MEM_BYTES - 8)) || (ALIGN && (a[2:0] != 3'd0));
        if (rej) begin
            cyc(1'b0, 1'b0, 1'b1, model_valm);
            clear_inputs();
            cyc(1'b0, 1'b0, 1'b0, model_valm);
            $display("txn %s rd=%b wr=%b addr=%h -> rejected", tag, rd, wr, a);
        end else begin
            base = int'(a[11:0]);
            cyc(1'b1, 1'b0, 1'b0, model_valm);
            clear_inputs();
            repeat (7) cyc(1'b1, 1'b0, 1'b0, model_valm);
            if (wr) begin
                for (int i = 0; i < 8; i++) mem_model[base + i] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < 8; i++) word[8*i +: 8] = mem_model[base + i];
                model_valm = word;
            end
            cyc(1'b1, 1'b1, 1'b0, model_valm);
            cyc(1'b0, 1'b0, 1'b0, model_valm);
            $display("txn %s rd=%b wr=%b addr=%h data=%h -> completed, model valM=%h",
                     tag, rd, wr, a, d, model_valm);
        end
    endtask

    initial begin
        int b0;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        $display("txn reset -> outputs expected zero");

        access(1'b0, 1'b1, 64'h100, 64'h1122334455667788, "write_0x100");
        check("ram_0x100", 64'(u_dut.u_ram.mem[12'h100]), 64'h88);
        check("ram_0x107", 64'(u_dut.u_ram.mem[12'h107]), 64'h11);

        b0 = busy_seen;
        access(1'b1, 1'b0, 64'h100, 64'd0, "read_0x100");
        check("read_literal", bus.valM, 64'h1122334455667788);
        check("busy_cycles", 64'(busy_seen - b0), 64'd9);

        access(1'b0, 1'b1, 64'(MEM_BYTES - 8), 64'h0123456789ABCDEF, "write_top");
        access(1'b1, 1'b0, 64'(MEM_BYTES - 7), 64'd0, "read_past_top");
        check("range_valM_held", bus.valM, 64'h1122334455667788);
        access(1'b1, 1'b0, 64'(MEM_BYTES - 8), 64'd0, "read_top");
        check("top_literal", bus.valM, 64'h0123456789ABCDEF);
        access(1'b1, 1'b0, 64'h1_0000_0100, 64'd0, "read_high_bits");

        access(1'b1, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, "conflict");
        repeat (20) cyc(1'b0, 1'b0, 1'b0, model_valm);
        $display("txn idle_20 -> no activity expected");

        access(1'b0, 1'b1, 64'h200, 64'd0, "clear_0x200");
        bus.memWrite = 1'b1;
        bus.addr     = 64'h200;
        bus.valIn    = 64'hAAAA_AAAA_AAAA_AAAA;
        cyc(1'b1, 1'b0, 1'b0, model_valm);
        clear_inputs();
        repeat (3) cyc(1'b1, 1'b0, 1'b0, model_valm);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) mem_model[12'h200 + i] = 8'hAA;
        model_valm = 64'd0;
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        $display("txn reset_mid_write addr=200 -> aborted after 3 bytes");
        access(1'b1, 1'b0, 64'h200, 64'd0, "read_0x200");
        check("partial_literal", bus.valM, 64'h0000_0000_00AA_AAAA);

        access(1'b0, 1'b1, 64'h108, 64'hCAFEBABEDEADBEEF, "write_0x108");
        access(1'b1, 1'b0, 64'h103, 64'd0, "read_0x103");
`ifdef DMEM_ALIGN_CHECK_EN
        check("unaligned_held", bus.valM, 64'h0000_0000_00AA_AAAA);
`else
        check("unaligned_literal", bus.valM, 64'hADBEEF1122334455);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
